// File: rtl/board_ctrl_pkg.sv
// board_ctrl_pkg: shared FSM encoding, default parameters and width helper for board_ctrl
package board_ctrl_pkg;
    typedef enum logic [1:0] {HOLD, IDLE, RUN, STEP} state_t;
    localparam int DEF_DATA_W          = 16;
    localparam int DEF_NUM_PARAMS      = 4;
    localparam int DEF_NUM_RESULTS     = 4;
    localparam int DEF_CLK_DIV_LOG2    = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 100000;
    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/board_ctrl_debounce.sv
// btn_debounce: accepts a button level change only after it persists DEBOUNCE_CYCLES cycles
module btn_debounce
    import board_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_btn,
    output logic out_level,
    output logic out_rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic hit;
    assign hit = (in_btn != out_level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt       <= '0;
            out_level <= 1'b0;
            out_rise  <= 1'b0;
        end else begin
            cnt       <= (in_btn == out_level || hit) ? '0 : cnt + 1'b1;
            out_level <= hit ? in_btn : out_level;
            out_rise  <= hit & in_btn;
        end
    end
endmodule

// File: rtl/board_ctrl.sv
// board_ctrl: parameter loading, core clock gating/reset FSM and result paging for a board-hosted core
module board_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int NUM_PARAMS      = DEF_NUM_PARAMS,
    parameter int NUM_RESULTS     = DEF_NUM_RESULTS,
    parameter int CLK_DIV_LOG2    = DEF_CLK_DIV_LOG2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                                 in_clk,
    input  logic                                 in_rst,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic [NUM_PARAMS-1:0]                in_load,
    input  logic                                 in_run,
    input  logic                                 in_step,
    input  logic                                 in_page,
    input  logic [NUM_RESULTS*32-1:0]            in_results,
    output logic [NUM_PARAMS*DATA_W-1:0]         out_params,
    output logic                                 out_core_en,
    output logic                                 out_core_rst,
    output logic [31:0]                          out_disp,
    output logic [clog2_min1(NUM_RESULTS)-1:0]   out_page,
    output logic [31:0]                          out_tick_count
);
    localparam int PAGE_W = clog2_min1(NUM_RESULTS);
    localparam int IDX_W  = clog2_min1(NUM_PARAMS);

    state_t state, next_state;
    logic [CLK_DIV_LOG2-1:0] div_cnt, hold_cnt;
    logic [IDX_W-1:0] load_idx;
    logic [DATA_W-1:0] params [NUM_PARAMS];
    logic [PAGE_W-1:0] page;
    logic tick, any_load, hold_done;
    logic step_rise, page_rise, step_level, page_level, unused_levels;

    assign tick          = &div_cnt;
    assign any_load      = |in_load;
    assign hold_done     = &hold_cnt;
    assign out_page      = page;
    assign unused_levels = step_level ^ page_level;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .in_clk(in_clk), .in_rst(in_rst), .in_btn(in_step),
        .out_level(step_level), .out_rise(step_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_page_db (
        .in_clk(in_clk), .in_rst(in_rst), .in_btn(in_page),
        .out_level(page_level), .out_rise(page_rise)
    );

    always_comb begin
        load_idx = '0;
        for (int i = NUM_PARAMS - 1; i >= 0; i--)
            if (in_load[i]) load_idx = IDX_W'(i);
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < NUM_PARAMS; i++) params[i] <= '0;
        end else if (any_load) begin
            params[load_idx] <= in_data;
        end
    end

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_params
        assign out_params[g*DATA_W +: DATA_W] = params[g];
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state <= HOLD;
        else        state <= next_state;
    end

    // A load overrides every state so the core never sees a half-updated parameter set
    always_comb begin
        next_state   = state;
        out_core_en  = 1'b0;
        out_core_rst = 1'b0;
        case (state)
            HOLD: begin
                out_core_rst = 1'b1;
                next_state   = hold_done ? IDLE : HOLD;
            end
            IDLE: next_state = in_run ? RUN : step_rise ? STEP : IDLE;
            RUN: begin
                out_core_en = tick;
                next_state  = in_run ? RUN : IDLE;
            end
            STEP: begin
                out_core_en = tick;
                next_state  = tick ? IDLE : STEP;
            end
            default: next_state = HOLD;
        endcase
        if (any_load) begin
            next_state  = HOLD;
            out_core_en = 1'b0;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            div_cnt        <= '0;
            hold_cnt       <= '0;
            out_tick_count <= '0;
        end else begin
            div_cnt        <= div_cnt + 1'b1;
            hold_cnt       <= (state == HOLD && !any_load) ? hold_cnt + 1'b1 : '0;
            out_tick_count <= (next_state == HOLD) ? '0 :
                              (out_core_en && !(&out_tick_count)) ? out_tick_count + 1'b1 :
                              out_tick_count;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            page     <= '0;
            out_disp <= '0;
        end else begin
            page     <= !page_rise ? page : (page == PAGE_W'(NUM_RESULTS - 1)) ? '0 : page + 1'b1;
            out_disp <= in_results[32*int'(page) +: 32];
        end
    end
endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: directed and randomized checks of board_ctrl against a spec-level model
module tb_board_ctrl;
    localparam int DW = 16;
    localparam int NP = 4;
    localparam int NR = 4;
    localparam int KL = 2;
    localparam int DB = 4;

    logic              in_clk = 1'b0;
    logic              in_rst, in_run, in_step, in_page;
    logic [DW-1:0]     in_data;
    logic [NP-1:0]     in_load;
    logic [NR*32-1:0]  in_results;
    logic [NP*DW-1:0]  out_params;
    logic              out_core_en, out_core_rst;
    logic [31:0]       out_disp, out_tick_count;
    logic [1:0]        out_page;

    int total = 0;
    int bad = 0;
    int cyc_no = 0;
    int en_q[$];
    logic [DW-1:0] mp [NP];
    logic [31:0]   rw [NR];
    int mpage;
    logic found;

    board_ctrl #(
        .DATA_W(DW), .NUM_PARAMS(NP), .NUM_RESULTS(NR),
        .CLK_DIV_LOG2(KL), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_data(in_data), .in_load(in_load),
        .in_run(in_run), .in_step(in_step), .in_page(in_page), .in_results(in_results),
        .out_params(out_params), .out_core_en(out_core_en), .out_core_rst(out_core_rst),
        .out_disp(out_disp), .out_page(out_page), .out_tick_count(out_tick_count)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: records this cycle's enable just before the edge, returns at next negedge
    task automatic nxt();
        #4;
        if (out_core_en === 1'b1) en_q.push_back(cyc_no);
        cyc_no++;
        @(negedge in_clk);
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) nxt();
    endtask

    function automatic logic [NP*DW-1:0] exp_params();
        logic [NP*DW-1:0] r;
        for (int i = 0; i < NP; i++) r[i*DW +: DW] = mp[i];
        return r;
    endfunction

    task automatic set_results();
        for (int i = 0; i < NR; i++) in_results[i*32 +: 32] = rw[i];
    endtask

    task automatic do_load(input logic [NP-1:0] ld, input logic [DW-1:0] d);
        in_load = ld;
        in_data = d;
        for (int i = 0; i < NP; i++) if (ld[i]) begin mp[i] = d; break; end
        nxt();
        in_load = '0;
    endtask

    task automatic chk_hold(input string tag);
        for (int i = 0; i < (1 << KL); i++) begin
            chk({tag, "_core_rst_hi"}, out_core_rst, 1);
            nxt();
        end
        chk({tag, "_core_rst_lo"}, out_core_rst, 0);
    endtask

    task automatic press_page();
        in_page = 1'b1;
        wait_n(6);
        in_page = 1'b0;
        wait_n(6);
        mpage = (mpage + 1) % NR;
        chk("page_idx", out_page, mpage);
        chk("page_disp", out_disp, rw[mpage]);
    endtask

    initial begin
        in_rst = 1'b1; in_run = 1'b0; in_step = 1'b0; in_page = 1'b0;
        in_data = '0; in_load = '0;
        rw[0] = 32'hA; rw[1] = 32'hB; rw[2] = 32'hC; rw[3] = 32'hD;
        set_results();
        for (int i = 0; i < NP; i++) mp[i] = '0;
        mpage = 0;
        @(negedge in_clk);
        wait_n(2);
        chk("rst_core_rst", out_core_rst, 1);
        chk("rst_core_en", out_core_en, 0);
        chk("rst_tick_count", out_tick_count, 0);
        chk("rst_disp", out_disp, 0);
        chk("rst_page", out_page, 0);
        chk("rst_params", out_params, 0);

        in_rst = 1'b0;
        chk_hold("release");
        chk("release_tick_count", out_tick_count, 0);
        chk("idle_disp", out_disp, rw[0]);

        do_load(4'b0100, 16'h1234);
        wait_n(6);
        do_load(4'b0110, 16'h0064);
        chk("load_param1", out_params[31:16], 16'h0064);
        chk("load_param2", out_params[47:32], 16'h1234);
        chk("load_params", out_params, exp_params());
        chk_hold("load");

        en_q.delete();
        in_run = 1'b1;
        wait_n(20);
        in_run = 1'b0;
        wait_n(6);
        chk("run_pulses", en_q.size(), 5);
        for (int i = 1; i < en_q.size(); i++) chk("run_gap", en_q[i] - en_q[i-1], 4);
        chk("run_tick_count", out_tick_count, 5);

        en_q.delete();
        in_step = 1'b1;
        wait_n(2);
        in_step = 1'b0;
        wait_n(10);
        chk("step_glitch", en_q.size(), 0);
        in_step = 1'b1;
        wait_n(6);
        in_step = 1'b0;
        wait_n(14);
        chk("step_pulses", en_q.size(), 1);
        chk("step_tick_count", out_tick_count, 6);

        chk("page0_disp", out_disp, rw[0]);
        for (int i = 0; i < 5; i++) press_page();

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NR; i++) rw[i] = $urandom;
            set_results();
            wait_n(2);
            chk("rand_disp", out_disp, rw[mpage]);
            do_load(4'($urandom_range(1, 15)), 16'($urandom));
            chk("rand_params", out_params, exp_params());
            chk("rand_core_rst", out_core_rst, 1);
            wait_n(5);
            if (k % 2 == 1) press_page();
        end

        en_q.delete();
        in_run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            int s;
            s = en_q.size();
            nxt();
            if (en_q.size() > s) found = 1'b1;
        end
        chk("run_en_seen", found, 1);
        wait_n(3);
        chk("run_tick_before_load", out_core_en, 1);
        chk("run_count_before_load", out_tick_count, en_q.size());
        in_run = 1'b0;
        in_load = 4'b1000;
        in_data = 16'($urandom);
        mp[3] = in_data;
        #1;
        chk("load_kills_en", out_core_en, 0);
        #3;
        if (out_core_en === 1'b1) en_q.push_back(cyc_no);
        cyc_no++;
        @(negedge in_clk);
        in_load = '0;
        chk("load_clears_count", out_tick_count, 0);
        chk("run_load_params", out_params, exp_params());
        chk_hold("run_load");
        wait_n(6);
        chk("idle_after_load", en_q.size(), 1);

        in_run = 1'b1;
        wait_n(7);
        in_rst = 1'b1;
        #1;
        chk("abort_core_en", out_core_en, 0);
        chk("abort_core_rst", out_core_rst, 1);
        chk("abort_tick_count", out_tick_count, 0);
        for (int i = 0; i < NP; i++) mp[i] = '0;
        mpage = 0;
        @(negedge in_clk);
        chk("abort_params", out_params, exp_params());
        chk("abort_page", out_page, mpage);
        chk("abort_disp", out_disp, 0);
        in_run = 1'b0;
        in_rst = 1'b0;
        chk_hold("rearm");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each switch-loaded parameter word.
REQ-002 SHALL have parameter NUM_PARAMS, default 4, number of loadable parameter registers.
REQ-003 SHALL have parameter NUM_RESULTS, default 4, number of 32-bit result words selectable for display.
REQ-004 SHALL have parameter CLK_DIV_LOG2, default 4, core tick period of 2^CLK_DIV_LOG2 in_clk cycles.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 100000, stable-input cycles required before a button edge counts.
REQ-006 SHALL have port in_clk, input, 1, the single clock for the block.
REQ-007 SHALL have port in_rst, input, 1, with reset asynchronous and active-high.
REQ-008 in_data  input  DATA_W  switch value to load.
REQ-009 in_load  input  NUM_PARAMS  level load strobes, one per parameter.
REQ-010 in_run  input  1  level; high requests free-running core.
REQ-011 in_step  input  1  raw button; single core tick request.
REQ-012 in_page  input  1  raw button; advance display page.
REQ-013 in_results  input  NUM_RESULTS*32  flattened core result words, word i at bits [32i+31:32i].
REQ-014 out_params  output  NUM_PARAMS*DATA_W  flattened parameter registers.
REQ-015 out_core_en  output  1  one-in_clk-wide core clock enable.
REQ-016 out_core_rst  output  1  core reset, active-high.
REQ-017 out_disp  output  32  word to 7-segment driver.
REQ-018 out_page  output  clog2(NUM_RESULTS) (min 1)  current page index.
REQ-019 out_tick_count  output  32  number of out_core_en pulses since last core reset.

Function
REQ-020 Parameters: each cycle, lowest index i with in_load[i]=1 SHALL load in_data into param i; higher set bits ignored that cycle.
REQ-021 Divider: CLK_DIV_LOG2-bit free-running counter; tick SHALL be true in the cycle the counter equals all-ones, then wrap to 0.
REQ-022 FSM states HOLD, IDLE, RUN, STEP; HOLD entered on reset.
REQ-023 HOLD: out_core_rst=1; SHALL stay 2^CLK_DIV_LOG2 cycles (hold counter), then go IDLE.
REQ-024 Any in_load bit high in any state SHALL reload the hold counter and enter HOLD; core never runs with a half-changed parameter.
REQ-025 IDLE: in_run=1 -> RUN; else debounced in_step rising edge -> STEP; in_run has priority when both occur.
REQ-026 RUN: out_core_en = tick; in_run=0 -> IDLE after the current cycle; step edges ignored.
REQ-027 STEP: out_core_en = tick; on that tick SHALL return to IDLE; exactly one pulse per accepted step.
REQ-028 out_core_en SHALL be 0 in HOLD and IDLE, never wider than one in_clk cycle.
REQ-029 Page: debounced in_page rising edge SHALL increment page, wrapping NUM_RESULTS-1 -> 0; works in all states.
REQ-030 out_disp SHALL be registered in_results word selected by page, 1-cycle latency.
REQ-031 out_tick_count SHALL increment on each out_core_en, saturate at 0xFFFFFFFF, clear to 0 while out_core_rst=1.
REQ-032 Debounce: edge SHALL be reported one cycle after input has differed from its stable value for DEBOUNCE_CYCLES consecutive cycles; shorter glitches discarded.

Reset
REQ-033 On in_rst: params 0, state HOLD, out_core_rst 1, out_core_en 0, page 0, out_disp 0, out_tick_count 0, divider 0, debouncers stable-low.
REQ-034 in_rst asserted mid-RUN or mid-STEP SHALL abort immediately; pending step discarded.

Structure
REQ-035 Shared package SHALL hold FSM state encoding and default parameter constants.
REQ-036 One sub-module btn_debounce (parameter DEBOUNCE_CYCLES; outputs stable level and rise pulse), instantiated for in_step and in_page.

Verification (bench: DATA_W=16, NUM_PARAMS=4, NUM_RESULTS=4, CLK_DIV_LOG2=2, DEBOUNCE_CYCLES=4)
REQ-037 Reset release -> out_core_rst high 4 cycles then low; out_core_en 0; out_tick_count 0.
REQ-038 in_load=4'b0110, in_data=0x0064 one cycle -> param1=0x0064, param2 unchanged, out_core_rst high 4 cycles.
REQ-039 in_run=1 for 20 cycles from IDLE -> 5 out_core_en pulses, 4 cycles apart; out_tick_count=5.
REQ-040 in_step pulse 2 cycles (glitch) -> no STEP; held 6 cycles -> exactly one out_core_en.
REQ-041 Five debounced in_page edges with in_results words 0xA,0xB,0xC,0xD -> out_disp B,C,D,A,B; out_page wraps 3->0.
REQ-042 in_load asserted during RUN -> out_core_en stops same cycle, out_tick_count cleared, returns IDLE after 4 cycles.
